// File: rtl/seq_array_mult.sv
// seq_array_mult -- sequential carry-save array multiplier.
//
// Multiplies two WIDTH-bit operands, one multiplier row per clock, using
// a row of WIDTH full-adder cells that keeps the running result in
// carry-save form.  The final carry-propagate addition is done on the
// same edge as the last row, so out_valid rises exactly WIDTH rising
// edges after the accept edge, whatever the operand values.
//
// Optional feature (compile-time macro):
//   SEQ_ARRAY_MULT_SIGNED_EN  defined   -> a, b, product are two's complement
//                                         (Baugh-Wooley sign handling)
//                             undefined -> unsigned operands and product
//
// Ports:
//   clk        in   clock, all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b present
//   in_ready   out  block can accept operands (IDLE)
//   a          in   WIDTH-bit multiplicand
//   b          in   WIDTH-bit multiplier
//   out_valid  out  product valid (DONE)
//   out_ready  in   consumer takes product
//   product    out  2*WIDTH-bit registered result
//   busy       out  high while not in IDLE

module seq_array_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  // Carry-save running result, aligned so that bit j carries weight
  // (row + j) for the row currently being processed.
  logic [WIDTH-1:0]   sum_reg;
  logic [WIDTH-1:0]   carry_reg;
  // Finished low-order product bits, shifted in from the top.
  logic [WIDTH-1:0]   low_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic               accept;
  logic               last_row;
  logic               b_bit;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH-1:0]   fa_sum;
  logic [WIDTH-1:0]   fa_carry;
  logic [WIDTH-1:0]   sum_shift;
  logic [WIDTH-1:0]   low_shift;
  logic [WIDTH-1:0]   final_hi;

  assign accept   = (state_reg == IDLE) && in_valid;
  assign last_row = (count_reg == LAST_ROW);
  assign b_bit    = b_reg[count_reg];

  // Partial-product row and full-adder cells, one per operand bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
      // Baugh-Wooley: terms that pair exactly one sign bit with a
      // magnitude bit are inverted (the last row is effectively
      // subtracted); the missing constants are added in final_hi.
      if (gi < WIDTH - 1) begin : g_mag
        assign pp[gi] = last_row ? ~(a_reg[gi] & b_bit) : (a_reg[gi] & b_bit);
      end else begin : g_sign
        assign pp[gi] = last_row ? (a_reg[gi] & b_bit) : ~(a_reg[gi] & b_bit);
      end
`else
      assign pp[gi] = a_reg[gi] & b_bit;
`endif
      assign fa_sum[gi]   = pp[gi] ^ sum_reg[gi] ^ carry_reg[gi];
      assign fa_carry[gi] = (pp[gi] & sum_reg[gi]) |
                            (pp[gi] & carry_reg[gi]) |
                            (sum_reg[gi] & carry_reg[gi]);
    end
  endgenerate

  // fa_sum[0] is final (weight == row); the remaining sum bits move down
  // one place to line up with the next row.  fa_carry already has
  // weight row+1+j, so it lines up without shifting.
  assign sum_shift = {1'b0, fa_sum[WIDTH-1:1]};
  assign low_shift = {fa_sum[0], low_reg[WIDTH-1:1]};

`ifdef SEQ_ARRAY_MULT_SIGNED_EN
  // Baugh-Wooley constants 2^WIDTH and 2^(2*WIDTH-1), expressed relative
  // to the upper half of the product.
  localparam logic [WIDTH-1:0] BW_CORR = WIDTH'(1) + (WIDTH'(1) << (WIDTH - 1));
  assign final_hi = sum_shift + fa_carry + BW_CORR;
`else
  assign final_hi = sum_shift + fa_carry;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)  state_next = CALC;
      CALC: if (last_row)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  assign product = product_reg;

  // Datapath registers.  product_reg is written only on the final row
  // edge, so it is stable throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      carry_reg   <= '0;
      low_reg     <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      sum_reg   <= '0;
      carry_reg <= '0;
      low_reg   <= '0;
      count_reg <= '0;
    end else if (state_reg == CALC) begin
      sum_reg   <= sum_shift;
      carry_reg <= fa_carry;
      low_reg   <= low_shift;
      if (last_row) begin
        count_reg   <= '0;
        product_reg <= {final_hi, low_shift};
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// tb_seq_array_mult -- self-checking bench for seq_array_mult (WIDTH=8).
// Directed cases (max operands, zero, sign cases, backpressure, reset
// mid-operation, operand changes while busy) followed by random operands,
// all checked against an arithmetic reference product.

module tb_seq_array_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks;
  int n_fail;

  seq_array_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain arithmetic on the operand values.
  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
    longint px;
    longint py;
    longint r;
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
    px = longint'($signed(x));
    py = longint'($signed(y));
`else
    px = longint'(x);
    py = longint'(y);
`endif
    r = px * py;
    return r[2*W-1:0];
  endfunction

  // One full transaction: accept, wait for out_valid (bounded), check
  // latency/product, hold for `hold` cycles under backpressure, then
  // complete the handshake while offering new operands that must not be
  // taken on the same edge.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int hold, input bit toggle);
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] held_p;
    int lat;
    exp_p = ref_mult(xa, xb);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (1) begin
      check("busy_running", busy, 1'b1);
      check("in_ready_running", in_ready, 1'b0);
      if (toggle) begin
        a = W'($urandom); b = W'($urandom); in_valid = $urandom_range(0, 1);
      end
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (lat > 40) break;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    check("product", product, exp_p);
    $display("op a=%0h b=%0h product=%0h expected=%0h latency=%0d", xa, xb, product, exp_p, lat);
    held_p = product;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_product", product, held_p);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
    @(posedge clk);
    #1;
    check("handshake_valid", out_valid, 1'b0);
    check("handshake_in_ready", in_ready, 1'b1);
    check("handshake_no_accept", busy, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    bit seen_valid;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_product", product, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'h00, 8'hA5, 0, 1'b0);
    run_op(8'h80, 8'h80, 0, 1'b0);
    run_op(8'hFF, 8'h01, 0, 1'b0);
    run_op(8'h7F, 8'h80, 5, 1'b0);
    run_op(8'h5A, 8'hC3, 0, 1'b1);

    // Reset during CALC row 3: outputs drop at once, no stale out_valid.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_product", product, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("midreset_no_valid", seen_valid, 1'b0);
    run_op(8'h03, 8'h05, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_op(W'($urandom), W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_array_mult.md
SEQ_ARRAY_MULT -- requirements
Module: seq_array_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operands a/b present.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  multiplicand.
REQ-007 Port: b  input  WIDTH  multiplier.
REQ-008 Port: out_valid  output  1  product valid.
REQ-009 Port: out_ready  input  1  consumer takes product.
REQ-010 Port: product  output  2*WIDTH  result of a*b.
REQ-011 Port: busy  output  1  high while not in IDLE.

Function
REQ-012 FSM states: IDLE, CALC, DONE; only these three encodings reachable.
REQ-013 IDLE: in_ready=1, out_valid=0; an accept occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-014 On accept: a and b are registered, partial-sum/carry registers cleared, row counter cleared to 0, state goes to CALC.
REQ-015 in_ready=0 in CALC and DONE; in_valid and a/b changes there are ignored.
REQ-016 CALC: one multiplier bit per cycle, row i (i=0..WIDTH-1) adds (a AND b[i]) shifted by i to the running sum using a row of WIDTH full-adder bit cells (carry-save sum plus carry).
REQ-017 Row counter increments by 1 per CALC cycle; at count WIDTH-1 the final carry-propagate resolution is done in the same edge and state goes to DONE.
REQ-018 Latency fixed: out_valid rises exactly WIDTH rising edges after the accept edge, independent of operand values (zero operands included).
REQ-019 DONE: out_valid=1, product holds the full 2*WIDTH result stable until handshake.
REQ-020 DONE with out_ready=1 on an edge: state goes to IDLE, out_valid falls; no operand accept on that same edge.
REQ-021 DONE with out_ready=0: state, product, out_valid held indefinitely.
REQ-022 product is registered; outside DONE its value is don't-care for consumers but SHALL not glitch in DONE.
REQ-023 No overflow: 2*WIDTH result width is exact for all operand pairs in both modes.
REQ-024 busy = (state != IDLE).

Reset
REQ-025 rst_n low: immediately (asynchronously) state=IDLE, counter=0, product=0, out_valid=0, in_ready=1, busy=0.
REQ-026 Reset asserted mid-CALC or in DONE aborts the operation; no out_valid pulse for the aborted operation after release.
REQ-027 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SEQ_ARRAY_MULT_SIGNED_EN defined: a, b, product are two's complement; row WIDTH-1 is subtracted (Baugh-Wooley sign correction) and the result is sign-correct over the full 2*WIDTH bits.
REQ-029 Macro SEQ_ARRAY_MULT_SIGNED_EN undefined: a, b, product unsigned; latency and handshake identical to signed mode.

Verification (WIDTH=8)
REQ-030 Unsigned: a=8'hFF, b=8'hFF accepted -> out_valid exactly 8 edges later, product=16'hFE01.
REQ-031 Zero: a=8'h00, b=8'hA5 -> product=16'h0000 with the same 8-edge latency; busy high throughout.
REQ-032 Signed build: a=8'h80, b=8'h80 -> product=16'h4000; a=8'hFF, b=8'h01 -> 16'hFFFF (unsigned build: 16'h00FF).
REQ-033 Backpressure: out_ready held 0 for 5 cycles in DONE -> product/out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Reset mid-op: rst_n pulsed low during CALC row 3 -> outputs at reset values immediately, no out_valid afterward; next op 8'h03*8'h05 -> 16'h000F.
REQ-035 Ignore rule: in_valid toggled with new operands during CALC -> result reflects only the originally accepted operands.
